// File: rtl/pattern_count_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pattern_count_engine                                             |
// | Brief   : Counts 5-bit pattern matches (in-byte and crossing-stream) over  |
// |           a byte string in data memory and writes three counts back.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pattern_count_engine #(
    parameter int NUM_BYTES = 32,
    parameter int PAT_ADDR  = 32,
    parameter int RES_ADDR  = 33,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_load_pat = 3'd1;
    localparam logic [2:0] c_st_scan     = 3'd2;
    localparam logic [2:0] c_st_wr_b     = 3'd3;
    localparam logic [2:0] c_st_wr_o     = 3'd4;
    localparam logic [2:0] c_st_wr_s     = 3'd5;
    localparam logic [2:0] c_st_done     = 3'd6;

    localparam logic [5:0] c_last_idx = 6'(NUM_BYTES - 1);

    logic [2:0]    r_state;
    logic [4:0]    r_pat;
    logic [7:0]    r_ctb;
    logic [7:0]    r_cto;
    logic [7:0]    r_cts;
    logic [3:0]    r_hist;
    logic [5:0]    r_idx;
    logic          r_done;
    logic          r_busy;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_wr_en;
    logic [7:0]    r_mem_wr_data;

    logic [11:0]   w_x;
    logic [2:0]    w_byte_cnt;
    logic [3:0]    w_cross_cnt;
    logic [7:0]    w_ctb_next;
    logic [7:0]    w_cto_next;
    logic [7:0]    w_cts_next;

    // The previous byte's low nibble extends the stream so windows can straddle
    // byte boundaries; on the first byte there is no history, so only the four
    // windows lying wholly inside the byte are counted.
    always_comb begin
        w_x         = {r_hist, mem_rd_data};
        w_byte_cnt  = 3'd0;
        w_cross_cnt = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (mem_rd_data[k +: 5] == r_pat) begin
                w_byte_cnt = w_byte_cnt + 3'd1;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (((r_idx != 6'd0) || (k >= 4)) && (w_x[11-k -: 5] == r_pat)) begin
                w_cross_cnt = w_cross_cnt + 4'd1;
            end
        end
        w_ctb_next = r_ctb + {5'd0, w_byte_cnt};
        w_cto_next = r_cto + {7'd0, (w_byte_cnt != 3'd0)};
        w_cts_next = r_cts + {4'd0, w_cross_cnt};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_pat         <= 5'd0;
            r_ctb         <= 8'd0;
            r_cto         <= 8'd0;
            r_cts         <= 8'd0;
            r_hist        <= 4'd0;
            r_idx         <= 6'd0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_data <= 8'd0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state    <= c_st_load_pat;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_mem_addr <= AW'(PAT_ADDR);
                        r_ctb      <= 8'd0;
                        r_cto      <= 8'd0;
                        r_cts      <= 8'd0;
                        r_hist     <= 4'd0;
                        r_idx      <= 6'd0;
                    end
                end
                c_st_load_pat: begin
                    r_pat      <= mem_rd_data[7:3];
                    r_mem_addr <= '0;
                    r_state    <= c_st_scan;
                end
                c_st_scan: begin
                    r_ctb  <= w_ctb_next;
                    r_cto  <= w_cto_next;
                    r_cts  <= w_cts_next;
                    r_hist <= mem_rd_data[3:0];
                    if (r_idx == c_last_idx) begin
                        // Last byte: the first result write uses the just-updated count.
                        r_state       <= c_st_wr_b;
                        r_mem_addr    <= AW'(RES_ADDR);
                        r_mem_wr_en   <= 1'b1;
                        r_mem_wr_data <= w_ctb_next;
                    end else begin
                        r_idx      <= r_idx + 6'd1;
                        r_mem_addr <= AW'(r_idx + 6'd1);
                    end
                end
                c_st_wr_b: begin
                    r_state       <= c_st_wr_o;
                    r_mem_addr    <= AW'(RES_ADDR + 1);
                    r_mem_wr_data <= r_cto;
                end
                c_st_wr_o: begin
                    r_state       <= c_st_wr_s;
                    r_mem_addr    <= AW'(RES_ADDR + 2);
                    r_mem_wr_data <= r_cts;
                end
                c_st_wr_s: begin
                    r_state       <= c_st_done;
                    r_mem_addr    <= '0;
                    r_mem_wr_en   <= 1'b0;
                    r_mem_wr_data <= 8'd0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign done        = r_done;
    assign busy        = r_busy;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_data = r_mem_wr_data;

endmodule
`default_nettype wire
